// File: rtl/write_buffer.sv
// Posted-write buffer between the CPU data port and the data cache.
// Writes are queued and acked early; reads may bypass unrelated queued writes.
module write_buffer #(
   parameter  int DEPTH       = 4,
   parameter  int BYPASS_READ = 1,
   localparam int PTR_W       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_data_req,
   input  logic             cpu_data_wr,
   input  logic [1:0]       cpu_data_size,
   input  logic [31:0]      cpu_data_addr,
   input  logic [31:0]      cpu_data_wdata,
   input  logic [3:0]       cpu_data_wstrb,
   output logic [31:0]      cpu_data_rdata,
   output logic             cpu_data_addr_ok,
   output logic             cpu_data_data_ok,
   output logic             dcache_data_req,
   output logic             dcache_data_wr,
   output logic [1:0]       dcache_data_size,
   output logic [31:0]      dcache_data_addr,
   output logic [31:0]      dcache_data_wdata,
   output logic [3:0]       dcache_data_wstrb,
   input  logic [31:0]      dcache_data_rdata,
   input  logic             dcache_data_addr_ok,
   input  logic             dcache_data_data_ok,
   output logic             wb_empty,
   output logic [PTR_W:0]   wb_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_WAIT,
      S_RD_WAIT
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [31:0]      r_addr  [DEPTH];
   logic [31:0]      r_wdata [DEPTH];
   logic [1:0]       r_size  [DEPTH];
   logic [3:0]       r_wstrb [DEPTH];

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic             r_wr_ack;

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [DEPTH-1:0] w_hit;
   logic             w_match;
   logic             w_rd_ok;
   logic             w_rd_elig;
   logic             w_drain;

   assign w_full = (r_count == (PTR_W+1)'(DEPTH));

   // The head retiring this cycle frees a slot for a push.
   assign w_pop = (r_state == S_WR_WAIT)
                & dcache_data_data_ok;

   assign w_push = cpu_data_req
                 & cpu_data_wr
                 & (r_state != S_RD_WAIT)
                 & (~w_full | w_pop);

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_hit[i] =
            ({1'b0, PTR_W'(i) - r_head} < r_count)
            && (r_addr[i][31:2] == cpu_data_addr[31:2]);
      end
   end

   assign w_match = |w_hit;

   always_comb begin
      if (BYPASS_READ != 0) begin
         w_rd_ok = ~w_match;
      end else begin
         w_rd_ok = (r_count == '0);
      end
   end

   assign w_rd_elig = cpu_data_req
                    & ~cpu_data_wr
                    & (r_state == S_IDLE)
                    & w_rd_ok;

   assign w_drain = (r_state == S_IDLE)
                  & ~w_rd_elig
                  & (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail]  <= cpu_data_addr;
         r_wdata[r_tail] <= cpu_data_wdata;
         r_size[r_tail]  <= cpu_data_size;
         r_wstrb[r_tail] <= cpu_data_wstrb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_wr_ack <= 1'b0;
      end else begin
         r_wr_ack <= w_push;
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_rd_elig && dcache_data_addr_ok) begin
               w_next = S_RD_WAIT;
            end else if (w_drain && dcache_data_addr_ok) begin
               w_next = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (dcache_data_data_ok) begin
               w_next = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            if (dcache_data_data_ok) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      dcache_data_req   = 1'b0;
      dcache_data_wr    = 1'b0;
      dcache_data_size  = r_size[r_head];
      dcache_data_addr  = r_addr[r_head];
      dcache_data_wdata = r_wdata[r_head];
      dcache_data_wstrb = r_wstrb[r_head];
      cpu_data_addr_ok  = w_push;
      cpu_data_data_ok  = r_wr_ack;
      if (w_rd_elig) begin
         dcache_data_req   = 1'b1;
         dcache_data_size  = cpu_data_size;
         dcache_data_addr  = cpu_data_addr;
         dcache_data_wdata = cpu_data_wdata;
         dcache_data_wstrb = cpu_data_wstrb;
         cpu_data_addr_ok  = dcache_data_addr_ok;
      end else if (w_drain) begin
         dcache_data_req   = 1'b1;
         dcache_data_wr    = 1'b1;
      end
      if ((r_state == S_RD_WAIT) && dcache_data_data_ok) begin
         cpu_data_data_ok = 1'b1;
      end
   end

   assign cpu_data_rdata = dcache_data_rdata;
   assign wb_empty = (r_count == '0) && (r_state != S_WR_WAIT);
   assign wb_count = r_count;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: cycle table plus hand sequences
// for bypass ordering and mid-transaction reset.
module tb_write_buffer;

   logic        clk;
   logic        rst;
   logic        cpu_data_req;
   logic        cpu_data_wr;
   logic [1:0]  cpu_data_size;
   logic [31:0] cpu_data_addr;
   logic [31:0] cpu_data_wdata;
   logic [3:0]  cpu_data_wstrb;
   logic [31:0] dcache_data_rdata;
   logic        dcache_data_addr_ok;
   logic        dcache_data_data_ok;

   logic [31:0] rdata1, rdata0;
   logic        aok1, aok0;
   logic        dok1, dok0;
   logic        dreq1, dreq0;
   logic        dwr1, dwr0;
   logic [1:0]  dsize1, dsize0;
   logic [31:0] daddr1, daddr0;
   logic [31:0] dwdata1, dwdata0;
   logic [3:0]  dwstrb1, dwstrb0;
   logic        empty1, empty0;
   logic [2:0]  cnt1, cnt0;

   int errors = 0;
   int checks = 0;

   write_buffer #(.DEPTH(4), .BYPASS_READ(1)) dut (
      .clk(clk), .rst(rst),
      .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
      .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
      .cpu_data_wdata(cpu_data_wdata), .cpu_data_wstrb(cpu_data_wstrb),
      .cpu_data_rdata(rdata1), .cpu_data_addr_ok(aok1),
      .cpu_data_data_ok(dok1),
      .dcache_data_req(dreq1), .dcache_data_wr(dwr1),
      .dcache_data_size(dsize1), .dcache_data_addr(daddr1),
      .dcache_data_wdata(dwdata1), .dcache_data_wstrb(dwstrb1),
      .dcache_data_rdata(dcache_data_rdata),
      .dcache_data_addr_ok(dcache_data_addr_ok),
      .dcache_data_data_ok(dcache_data_data_ok),
      .wb_empty(empty1), .wb_count(cnt1)
   );

   write_buffer #(.DEPTH(4), .BYPASS_READ(0)) dut0 (
      .clk(clk), .rst(rst),
      .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
      .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
      .cpu_data_wdata(cpu_data_wdata), .cpu_data_wstrb(cpu_data_wstrb),
      .cpu_data_rdata(rdata0), .cpu_data_addr_ok(aok0),
      .cpu_data_data_ok(dok0),
      .dcache_data_req(dreq0), .dcache_data_wr(dwr0),
      .dcache_data_size(dsize0), .dcache_data_addr(daddr0),
      .dcache_data_wdata(dwdata0), .dcache_data_wstrb(dwstrb0),
      .dcache_data_rdata(dcache_data_rdata),
      .dcache_data_addr_ok(dcache_data_addr_ok),
      .dcache_data_data_ok(dcache_data_data_ok),
      .wb_empty(empty0), .wb_count(cnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        daok;
      logic        ddok;
      logic [31:0] drd;
      logic        e_aok;
      logic        e_dok;
      logic        e_dreq;
      logic        e_dwr;
      logic [31:0] e_daddr;
      logic [31:0] e_dwd;
      logic [2:0]  e_cnt;
      logic        e_empty;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input bit rs, input bit rq, input bit w,
      input logic [31:0] a, input logic [31:0] wd,
      input bit ao, input bit dk, input logic [31:0] rd,
      input bit eao, input bit edk, input bit erq, input bit ewr,
      input logic [31:0] ea, input logic [31:0] ewd,
      input logic [2:0] ec, input bit ee);
      vec_t v;
      v.rst = rs; v.req = rq; v.wr = w;
      v.addr = a; v.wdata = wd;
      v.daok = ao; v.ddok = dk; v.drd = rd;
      v.e_aok = eao; v.e_dok = edk;
      v.e_dreq = erq; v.e_dwr = ewr;
      v.e_daddr = ea; v.e_dwd = ewd;
      v.e_cnt = ec; v.e_empty = ee;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst                 = v.rst;
      cpu_data_req        = v.req;
      cpu_data_wr         = v.wr;
      cpu_data_addr       = v.addr;
      cpu_data_wdata      = v.wdata;
      dcache_data_addr_ok = v.daok;
      dcache_data_data_ok = v.ddok;
      dcache_data_rdata   = v.drd;
      #1;
   endtask

   task automatic check_vec(input vec_t v, input int i);
      chk($sformatf("v%0d.addr_ok", i), 32'(aok1), 32'(v.e_aok));
      chk($sformatf("v%0d.data_ok", i), 32'(dok1), 32'(v.e_dok));
      chk($sformatf("v%0d.dreq", i), 32'(dreq1), 32'(v.e_dreq));
      chk($sformatf("v%0d.count", i), 32'(cnt1), 32'(v.e_cnt));
      chk($sformatf("v%0d.empty", i), 32'(empty1), 32'(v.e_empty));
      if (v.e_dreq) begin
         chk($sformatf("v%0d.dwr", i), 32'(dwr1), 32'(v.e_dwr));
         chk($sformatf("v%0d.daddr", i), daddr1, v.e_daddr);
         if (v.e_dwr) begin
            chk($sformatf("v%0d.dwdata", i), dwdata1, v.e_dwd);
            chk($sformatf("v%0d.dwstrb", i), 32'(dwstrb1), 32'hF);
            chk($sformatf("v%0d.dsize", i), 32'(dsize1), 32'd2);
         end
      end
      if (v.e_dok && v.ddok) begin
         chk($sformatf("v%0d.rdata", i), rdata1, v.drd);
      end
   endtask

   vec_t s;

   initial begin
      rst = 1'b1;
      cpu_data_req = 1'b0;
      cpu_data_wr = 1'b0;
      cpu_data_size = 2'd2;
      cpu_data_addr = '0;
      cpu_data_wdata = '0;
      cpu_data_wstrb = 4'hF;
      dcache_data_rdata = '0;
      dcache_data_addr_ok = 1'b0;
      dcache_data_data_ok = 1'b0;

      // fill to full with downstream stalled, then push on a pop
      tbl[0]  = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);
      tbl[1]  = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);
      tbl[2]  = mk(0,1,1,32'h10,32'hA10,0,0,0, 1,0,0,0,0,0,0,1);
      tbl[3]  = mk(0,1,1,32'h14,32'hA14,0,0,0, 1,1,1,1,32'h10,32'hA10,1,0);
      tbl[4]  = mk(0,1,1,32'h18,32'hA18,0,0,0, 1,1,1,1,32'h10,32'hA10,2,0);
      tbl[5]  = mk(0,1,1,32'h1C,32'hA1C,0,0,0, 1,1,1,1,32'h10,32'hA10,3,0);
      tbl[6]  = mk(0,1,1,32'h20,32'hA20,0,0,0, 0,1,1,1,32'h10,32'hA10,4,0);
      tbl[7]  = mk(0,1,1,32'h20,32'hA20,1,0,0, 0,0,1,1,32'h10,32'hA10,4,0);
      tbl[8]  = mk(0,1,1,32'h20,32'hA20,0,1,0, 1,0,0,0,0,0,4,0);
      tbl[9]  = mk(0,0,0,0,0,0,0,0, 0,1,1,1,32'h14,32'hA14,4,0);
      tbl[10] = mk(0,1,0,32'h20,0,1,0,0, 0,0,1,1,32'h14,32'hA14,4,0);
      tbl[11] = mk(0,1,0,32'h20,0,0,1,0, 0,0,0,0,0,0,4,0);
      // bypass read, write refused in RD_WAIT, matching read stalls
      tbl[12] = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);
      tbl[13] = mk(0,1,1,32'h100,32'hDEADBEEF,0,0,0, 1,0,0,0,0,0,0,1);
      tbl[14] = mk(0,1,0,32'h104,0,1,0,0, 1,1,1,0,32'h104,0,1,0);
      tbl[15] = mk(0,1,1,32'h108,32'h11110108,0,0,0, 0,0,0,0,0,0,1,0);
      tbl[16] = mk(0,1,1,32'h108,32'h11110108,0,1,32'h1234,
                   0,1,0,0,0,0,1,0);
      tbl[17] = mk(0,1,1,32'h108,32'h11110108,0,0,0,
                   1,0,1,1,32'h100,32'hDEADBEEF,1,0);
      tbl[18] = mk(0,1,0,32'h102,0,1,0,0,
                   0,1,1,1,32'h100,32'hDEADBEEF,2,0);
      tbl[19] = mk(0,1,0,32'h102,0,0,1,0, 0,0,0,0,0,0,2,0);
      tbl[20] = mk(0,1,0,32'h102,0,1,0,0, 1,0,1,0,32'h102,0,1,0);
      tbl[21] = mk(0,0,0,0,0,0,1,32'hDEADBEEF, 0,1,0,0,0,0,1,0);
      tbl[22] = mk(0,0,0,0,0,0,1,0,
                   0,0,1,1,32'h108,32'h11110108,1,0);
      tbl[23] = mk(0,0,0,0,0,0,0,0,
                   0,0,1,1,32'h108,32'h11110108,1,0);

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i]);
         check_vec(tbl[i], i);
      end

      // BYPASS_READ=1 vs 0 on the same stimulus
      s = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("b.rst_cnt0", 32'(cnt0), 32'd0);
      chk("b.rst_empty0", 32'(empty0), 32'd1);
      s = mk(0,1,1,32'h100,32'hCAFE0100,0,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("b.wr_aok1", 32'(aok1), 32'd1);
      chk("b.wr_aok0", 32'(aok0), 32'd1);
      s = mk(0,1,0,32'h104,0,1,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("b.rd_aok1", 32'(aok1), 32'd1);
      chk("b.rd_dwr1", 32'(dwr1), 32'd0);
      chk("b.rd_daddr1", daddr1, 32'h104);
      chk("b.rd_aok0", 32'(aok0), 32'd0);
      chk("b.drain_dreq0", 32'(dreq0), 32'd1);
      chk("b.drain_dwr0", 32'(dwr0), 32'd1);
      chk("b.drain_daddr0", daddr0, 32'h100);
      chk("b.drain_dwd0", dwdata0, 32'hCAFE0100);
      chk("b.drain_size0", 32'(dsize0), 32'd2);
      chk("b.drain_strb0", 32'(dwstrb0), 32'hF);
      s = mk(0,1,0,32'h104,0,0,1,0, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("b.wait_aok0", 32'(aok0), 32'd0);
      chk("b.wait_empty0", 32'(empty0), 32'd0);
      chk("b.rd_dok1", 32'(dok1), 32'd1);
      s = mk(0,1,0,32'h104,0,1,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("b.after_empty0", 32'(empty0), 32'd1);
      chk("b.after_aok0", 32'(aok0), 32'd1);
      chk("b.after_dwr0", 32'(dwr0), 32'd0);
      chk("b.after_daddr0", daddr0, 32'h104);
      s = mk(0,0,0,0,0,0,1,32'h0BAD0000, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("b.rsp_dok0", 32'(dok0), 32'd1);
      chk("b.rsp_rdata0", rdata0, 32'h0BAD0000);

      // reset while a drain is in flight with three entries
      s = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      s = mk(0,1,1,32'h100,32'h1,0,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      s = mk(0,1,1,32'h104,32'h2,0,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      s = mk(0,1,1,32'h108,32'h3,1,0,0, 0,0,0,0,0,0,0,0);
      apply(s);
      chk("r.cnt2", 32'(cnt1), 32'd2);
      chk("r.issue_addr", daddr1, 32'h100);
      @(negedge clk);
      cpu_data_req = 1'b0;
      cpu_data_wr = 1'b0;
      dcache_data_addr_ok = 1'b0;
      #1;
      chk("r.cnt3", 32'(cnt1), 32'd3);
      chk("r.wrwait_empty", 32'(empty1), 32'd0);
      chk("r.wrwait_dreq", 32'(dreq1), 32'd0);
      rst = 1'b1;
      #1;
      chk("r.async_aok", 32'(aok1), 32'd0);
      chk("r.async_dok", 32'(dok1), 32'd0);
      chk("r.async_dreq", 32'(dreq1), 32'd0);
      chk("r.async_empty", 32'(empty1), 32'd1);
      chk("r.async_cnt", 32'(cnt1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cpu_data_req = 1'b1;
      cpu_data_addr = 32'h100;
      dcache_data_addr_ok = 1'b1;
      dcache_data_data_ok = 1'b1;
      #1;
      chk("r.rd_aok", 32'(aok1), 32'd1);
      chk("r.rd_dreq", 32'(dreq1), 32'd1);
      chk("r.rd_dwr", 32'(dwr1), 32'd0);
      chk("r.rd_daddr", daddr1, 32'h100);
      chk("r.stray_dok", 32'(dok1), 32'd0);
      @(negedge clk);
      cpu_data_req = 1'b0;
      dcache_data_addr_ok = 1'b0;
      dcache_data_data_ok = 1'b0;
      #1;
      chk("r.rdwait_dreq", 32'(dreq1), 32'd0);
      chk("r.rdwait_dok", 32'(dok1), 32'd0);
      @(negedge clk);
      dcache_data_data_ok = 1'b1;
      dcache_data_rdata = 32'h5555AAAA;
      #1;
      chk("r.rsp_dok", 32'(dok1), 32'd1);
      chk("r.rsp_rdata", rdata1, 32'h5555AAAA);
      @(negedge clk);
      dcache_data_data_ok = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of posted-write entries (power of two, >=2); PTR_W = clog2(DEPTH).
REQ-002 Parameter BYPASS_READ, default 1, selects read ordering: 1 = reads to unbuffered words overtake queued writes; 0 = every read waits for an empty buffer.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 cpu_data_req/wr  in  1/1  CPU request valid, write flag.
REQ-006 cpu_data_size/addr/wdata/wstrb  in  2/32/32/4  CPU request payload.
REQ-007 cpu_data_rdata  out  32  read data, valid with cpu_data_data_ok for reads.
REQ-008 cpu_data_addr_ok/data_ok  out  1/1  request accepted / response complete.
REQ-009 dcache_data_req/wr  out  1/1  downstream request valid, write flag.
REQ-010 dcache_data_size/addr/wdata/wstrb  out  2/32/32/4  downstream payload.
REQ-011 dcache_data_rdata  in  32  downstream read data.
REQ-012 dcache_data_addr_ok/data_ok  in  1/1  downstream accept / response.
REQ-013 wb_empty  out  1  high when no entry is queued or in flight.
REQ-014 wb_count  out  PTR_W+1  number of occupied entries.

Function
REQ-015 Entry holds {addr, size, wdata, wstrb}; circular FIFO; head/tail pointers wrap modulo DEPTH.
REQ-016 CPU write accepted (cpu_data_addr_ok=1, combinational) when req&wr, state!=RD_WAIT, and (count<DEPTH or head pops this cycle); entry pushed at that edge.
REQ-017 Accepted write gets cpu_data_data_ok exactly one cycle later, independent of the downstream.
REQ-018 Read match = any valid entry (including the in-flight head) with addr[31:2] equal to cpu_data_addr[31:2].
REQ-019 CPU read is eligible in IDLE when (BYPASS_READ=1 and no match) or (BYPASS_READ=0 and count==0); otherwise cpu_data_addr_ok=0 (stall).
REQ-020 Eligible read passes through: dcache_data_req=1 with CPU payload; cpu_data_addr_ok = dcache_data_addr_ok; on accept -> RD_WAIT.
REQ-021 In IDLE with no eligible read pending and count>0, head is issued as a downstream write; on dcache_data_addr_ok -> WR_WAIT.
REQ-022 Eligible CPU read has priority over draining in IDLE; write pushes never block a drain.
REQ-023 WR_WAIT: dcache_data_req=0; on dcache_data_data_ok pop head (count-1, head+1) -> IDLE.
REQ-024 RD_WAIT: dcache_data_req=0; on dcache_data_data_ok assert cpu_data_data_ok, cpu_data_rdata=dcache_data_rdata -> IDLE.
REQ-025 At most one downstream transaction outstanding; downstream data_ok outside WR_WAIT/RD_WAIT is ignored.
REQ-026 Push and pop in the same cycle leave count unchanged; count never exceeds DEPTH nor drops below 0.
REQ-027 cpu_data_data_ok for a write and for a read never coincide; writes are refused in RD_WAIT to keep CPU responses in order.
REQ-028 wb_empty = (count==0) and state!=WR_WAIT.

Reset
REQ-029 On rst: count=0, pointers=0, state=IDLE, pending write ack=0; entry storage need not clear.
REQ-030 During and after reset until a new request: cpu_data_addr_ok=0, cpu_data_data_ok=0, dcache_data_req=0, wb_empty=1, wb_count=0.
REQ-031 rst mid-transaction discards queued and in-flight entries; later stray dcache_data_data_ok is ignored.

Verification
REQ-032 DEPTH=4, dcache addr_ok held 0, 5 back-to-back writes -> first 4 acked 1 cycle later, 5th stalls, wb_count=4.
REQ-033 Full buffer, head data_ok same cycle as 5th write req -> write accepted, wb_count stays 4.
REQ-034 Queued write to 0x100, read 0x104 with BYPASS_READ=1 -> read issued before drain; with BYPASS_READ=0 -> read waits until wb_empty=1.
REQ-035 Queued write 0x100=0xDEADBEEF, read 0x102 -> read stalls until pop, then returns 0xDEADBEEF from dcache.
REQ-036 Read in RD_WAIT plus CPU write req -> write addr_ok=0 until read data_ok, responses in order.
REQ-037 rst asserted in WR_WAIT with 3 entries -> outputs immediately per REQ-030, next read passes through unblocked.
